// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the text console writer: FSM states and control codes.
package text_console_writer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWchr,
    StWatr,
    StScrRd,
    StScrWr,
    StScrClr,
    StCls
  } state_e;

  localparam logic [7:0] CodeCr = 8'h0D;
  localparam logic [7:0] CodeLf = 8'h0A;
  localparam logic [7:0] CodeBs = 8'h08;
  localparam logic [7:0] CodeFf = 8'h0C;

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream writer for the text video RAM: prints characters, handles CR/LF/BS/FF,
// scrolls the screen up one row when the cursor runs off the bottom, and tracks the cursor cell.
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 25,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  output logic [11:0] vr_address,
  output logic [7:0]  vr_wdata,
  output logic        vr_we,
  input  logic [7:0]  vr_rdata,
  output logic [10:0] cursor,
  output logic        busy
);

  localparam logic [11:0] RowBytes    = 12'(COLS * 2);
  localparam logic [11:0] ScrollBytes = 12'((ROWS - 1) * COLS * 2);
  localparam logic [11:0] ScreenBytes = 12'(ROWS * COLS * 2);

  state_e      state_q;
  logic [4:0]  row_q;
  logic [6:0]  col_q;
  logic [10:0] cursor_q;
  logic [11:0] cnt_q;
  logic [11:0] addr_q;
  logic [7:0]  wdata_q;
  logic        we_q;
  logic [7:0]  attr_q;

  logic [10:0] col_ext;
  logic [4:0]  adv_row;
  logic [6:0]  adv_col;
  logic [10:0] adv_cursor;
  logic        adv_scroll;

  assign col_ext = {4'b0000, col_q};

  // Cursor advance after a printed character, including wrap and scroll detection.
  always_comb begin
    adv_scroll = 1'b0;
    adv_row    = row_q;
    adv_col    = col_q + 7'd1;
    adv_cursor = cursor_q + 11'd1;
    if (col_q == 7'(COLS - 1)) begin
      adv_col = 7'd0;
      if (row_q == 5'(ROWS - 1)) begin
        adv_scroll = 1'b1;
        adv_cursor = cursor_q - 11'(COLS - 1);
      end else begin
        adv_row = row_q + 5'd1;
      end
    end
  end

  // Main FSM: command decode, RAM sequencing and cursor bookkeeping.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      col_q    <= '0;
      cursor_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      attr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          we_q <= 1'b0;
          if (in_valid) begin
            attr_q <= attr;
            case (in_data)
              CodeCr: begin
                col_q    <= '0;
                cursor_q <= cursor_q - col_ext;
              end
              CodeLf: begin
                col_q    <= '0;
                cursor_q <= cursor_q - col_ext;
                if (row_q == 5'(ROWS - 1)) begin
                  state_q <= StScrRd;
                  cnt_q   <= '0;
                  addr_q  <= RowBytes;
                end else begin
                  row_q    <= row_q + 5'd1;
                  cursor_q <= cursor_q - col_ext + 11'(COLS);
                end
              end
              CodeBs: begin
                if (col_q != 7'd0) begin
                  col_q    <= col_q - 7'd1;
                  cursor_q <= cursor_q - 11'd1;
                end
              end
              CodeFf: begin
                state_q <= StCls;
                we_q    <= 1'b1;
                addr_q  <= '0;
                wdata_q <= BLANK_CHAR;
              end
              default: begin
                state_q <= StWchr;
                we_q    <= 1'b1;
                addr_q  <= {cursor_q, 1'b0};
                wdata_q <= in_data;
              end
            endcase
          end
        end
        StWchr: begin
          state_q <= StWatr;
          addr_q  <= {cursor_q, 1'b1};
          wdata_q <= attr_q;
        end
        StWatr: begin
          we_q     <= 1'b0;
          row_q    <= adv_row;
          col_q    <= adv_col;
          cursor_q <= adv_cursor;
          if (adv_scroll) begin
            state_q <= StScrRd;
            cnt_q   <= '0;
            addr_q  <= RowBytes;
          end else begin
            state_q <= StIdle;
          end
        end
        StScrRd: begin
          state_q <= StScrWr;
          we_q    <= 1'b1;
          addr_q  <= cnt_q;
        end
        StScrWr: begin
          if (cnt_q == ScrollBytes - 12'd1) begin
            state_q <= StScrClr;
            addr_q  <= ScrollBytes;
            wdata_q <= BLANK_CHAR;
          end else begin
            state_q <= StScrRd;
            we_q    <= 1'b0;
            cnt_q   <= cnt_q + 12'd1;
            addr_q  <= cnt_q + 12'd1 + RowBytes;
          end
        end
        StScrClr, StCls: begin
          if (addr_q == ScreenBytes - 12'd1) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            if (state_q == StCls) begin
              row_q    <= '0;
              col_q    <= '0;
              cursor_q <= '0;
            end
          end else begin
            addr_q  <= addr_q + 12'd1;
            // Even bytes are characters, odd bytes attributes.
            wdata_q <= addr_q[0] ? BLANK_CHAR : attr_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM read data lands one cycle after its address, i.e. in the write cycle itself,
  // so the scroll copy forwards it straight through instead of through wdata_q.
  assign vr_wdata   = (state_q == StScrWr) ? vr_rdata : wdata_q;
  assign vr_address = addr_q;
  assign vr_we      = we_q;
  assign cursor     = cursor_q;
  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: synchronous RAM model, write monitor and an
// array-based screen model that predicts writes, latency and cursor per byte.
module tb_text_console_writer;

  logic        clock_25 = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr;
  logic [11:0] vr_address;
  logic [7:0]  vr_wdata;
  logic        vr_we;
  logic [7:0]  vr_rdata;
  logic [10:0] cursor;
  logic        busy;

  always #20 clock_25 = ~clock_25;

  text_console_writer dut (
    .clock_25  (clock_25),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .attr      (attr),
    .vr_address(vr_address),
    .vr_wdata  (vr_wdata),
    .vr_we     (vr_we),
    .vr_rdata  (vr_rdata),
    .cursor    (cursor),
    .busy      (busy)
  );

  // Synchronous video RAM with a preload port used only before the test starts.
  logic [7:0]  mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [7:0]  pre_val;
  always @(posedge clock_25) begin
    if (pre_en) mem[pre_addr] <= pre_val;
    else if (vr_we) mem[vr_address] <= vr_wdata;
    vr_rdata <= mem[vr_address];
  end

  int cyc = 0;
  always @(posedge clock_25) cyc <= cyc + 1;

  typedef struct {int cyc; logic [11:0] addr; logic [7:0] data;} wr_t;
  wr_t wlog[$];
  always @(negedge clock_25) if (vr_we && !reset) wlog.push_back('{cyc, vr_address, vr_wdata});

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Screen model: plain array, row/col, expected write list and latency.
  logic [7:0] ref_mem [0:3999];
  int m_row, m_col;
  typedef struct {logic [11:0] addr; logic [7:0] data;} ew_t;
  ew_t exp_w[$];

  task automatic model_put(input int a, input logic [7:0] v);
    ref_mem[a] = v;
    exp_w.push_back('{12'(a), v});
  endtask

  task automatic model_scroll(input logic [7:0] a);
    for (int i = 0; i < 3840; i++) model_put(i, ref_mem[i + 160]);
    for (int i = 3840; i < 4000; i++) model_put(i, (i % 2 == 0) ? 8'h20 : a);
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [7:0] a, output int lat);
    int n;
    exp_w.delete();
    lat = 1;
    case (b)
      8'h0D: m_col = 0;
      8'h0A: begin
        m_col = 0;
        if (m_row < 24) m_row++;
        else begin model_scroll(a); lat += 7840; end
      end
      8'h08: if (m_col > 0) m_col--;
      8'h0C: begin
        for (int i = 0; i < 4000; i++) model_put(i, (i % 2 == 0) ? 8'h20 : a);
        m_row = 0;
        m_col = 0;
        lat = 4001;
      end
      default: begin
        n = m_row * 80 + m_col;
        model_put(2 * n, b);
        model_put(2 * n + 1, a);
        lat = 3;
        m_col++;
        if (m_col == 80) begin
          m_col = 0;
          if (m_row == 24) begin model_scroll(a); lat += 7840; end
          else m_row++;
        end
      end
    endcase
  endtask

  task automatic do_byte(input logic [7:0] b, input logic [7:0] a, input string tag,
                         output int acc_o, output int wst_o);
    int lat_exp, waited, mism, first_bad, nw;
    waited = 0;
    while (!in_ready && waited < 20000) begin @(negedge clock_25); waited++; end
    if (!in_ready) check_eq({tag, " ready_before"}, 32'(in_ready), 32'd1);
    wst_o = wlog.size();
    model_byte(b, a, lat_exp);
    in_data  = b;
    attr     = a;
    in_valid = 1'b1;
    acc_o    = cyc;
    @(negedge clock_25);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    attr     = 8'($urandom);
    waited   = 1;
    while (!in_ready && waited < lat_exp + 50) begin @(negedge clock_25); waited++; end
    check_eq({tag, " latency"}, 32'(cyc - acc_o), 32'(lat_exp));
    nw = wlog.size() - wst_o;
    check_eq({tag, " wr_count"}, 32'(nw), 32'(exp_w.size()));
    mism = 0;
    first_bad = -1;
    for (int i = 0; i < nw && i < exp_w.size(); i++) begin
      if (wlog[wst_o + i].addr !== exp_w[i].addr || wlog[wst_o + i].data !== exp_w[i].data) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (mism != 0) $display("  first bad write index %0d", first_bad);
    check_eq({tag, " wr_seq_bad"}, 32'(mism), 32'd0);
    check_eq({tag, " cursor"}, 32'(cursor), 32'(m_row * 80 + m_col));
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_mem(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 4000; i++) if (mem[i] !== ref_mem[i]) mism++;
    check_eq({tag, " mem_bad_bytes"}, 32'(mism), 32'd0);
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(8'h21, 8'h7E));
  endfunction

  initial begin
    #3600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, wst, r;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    attr     = '0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_val  = '0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock_25);
      pre_en      = 1'b1;
      pre_addr    = 12'(i);
      pre_val     = 8'($urandom);
      ref_mem[i]  = pre_val;
    end
    @(negedge clock_25);
    pre_en = 1'b0;
    @(negedge clock_25);
    check_eq("rst cursor", 32'(cursor), 32'd0);
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst vr_we", 32'(vr_we), 32'd0);
    check_eq("rst vr_address", 32'(vr_address), 32'd0);
    check_eq("rst vr_wdata", 32'(vr_wdata), 32'd0);
    reset = 1'b0;
    m_row = 0;
    m_col = 0;

    // Single character with exact write timing.
    do_byte(8'h41, 8'h1E, "t1_A", acc, wst);
    if (wlog.size() >= wst + 2) begin
      check_eq("t1 char_cycle", 32'(wlog[wst].cyc - acc), 32'd1);
      check_eq("t1 attr_cycle", 32'(wlog[wst + 1].cyc - acc), 32'd2);
    end else begin
      check_eq("t1 write_present", 32'(wlog.size() - wst), 32'd2);
    end
    check_eq("t1 cursor", 32'(cursor), 32'd1);

    // Fill to end of first row.
    for (int i = 0; i < 79; i++) do_byte(rand_print(), 8'($urandom), "t2_fill", acc, wst);
    check_eq("t2 cursor", 32'(cursor), 32'd80);

    // Cursor controls.
    for (int i = 0; i < 5; i++) do_byte(rand_print(), 8'($urandom), "t3_fill", acc, wst);
    check_eq("t3 cursor85", 32'(cursor), 32'd85);
    do_byte(8'h08, 8'($urandom), "t3_bs", acc, wst);
    check_eq("t3 bs", 32'(cursor), 32'd84);
    do_byte(8'h0D, 8'($urandom), "t3_cr", acc, wst);
    check_eq("t3 cr", 32'(cursor), 32'd80);
    do_byte(8'h08, 8'($urandom), "t3_bs0", acc, wst);
    check_eq("t3 bs_noop", 32'(cursor), 32'd80);
    do_byte(8'h0A, 8'($urandom), "t3_lf", acc, wst);
    check_eq("t3 lf", 32'(cursor), 32'd160);

    // Drive cursor to the last cell, then print to force a scroll.
    while (m_row < 24) do_byte(8'h0A, 8'($urandom), "t4_lf", acc, wst);
    for (int i = 0; i < 79; i++) do_byte(rand_print(), 8'($urandom), "t4_fill", acc, wst);
    check_eq("t4 cursor1999", 32'(cursor), 32'd1999);
    do_byte(8'h5A, 8'($urandom), "t4_scroll", acc, wst);
    check_eq("t4 cursor1920", 32'(cursor), 32'd1920);
    check_mem("t4");
    do_byte(8'h0A, 8'($urandom), "t4_lfscroll", acc, wst);
    check_mem("t4b");

    // Form feed.
    do_byte(8'h0C, 8'h07, "t5_ff", acc, wst);
    check_eq("t5 cursor", 32'(cursor), 32'd0);
    check_eq("t5 in_ready", 32'(in_ready), 32'd1);
    check_mem("t5");

    // Random mix of printable and control bytes.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 15));
      case (r)
        0: do_byte(8'h0D, 8'($urandom), "t6_cr", acc, wst);
        1, 2: do_byte(8'h0A, 8'($urandom), "t6_lf", acc, wst);
        3: do_byte(8'h08, 8'($urandom), "t6_bs", acc, wst);
        default: do_byte(8'($urandom_range(8'h20, 8'h7E)), 8'($urandom), "t6_chr", acc, wst);
      endcase
    end
    check_mem("t6");

    // Reset in the middle of a scroll.
    while (m_row < 24) do_byte(8'h0A, 8'($urandom), "t7_lf", acc, wst);
    in_data  = 8'h0A;
    attr     = 8'h55;
    in_valid = 1'b1;
    @(negedge clock_25);
    in_valid = 1'b0;
    repeat (2000) @(negedge clock_25);
    check_eq("t7 busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock_25);
    check_eq("t7 vr_we", 32'(vr_we), 32'd0);
    check_eq("t7 in_ready", 32'(in_ready), 32'd1);
    check_eq("t7 cursor", 32'(cursor), 32'd0);
    check_eq("t7 busy", 32'(busy), 32'd0);
    reset = 1'b0;
    m_row = 0;
    m_col = 0;
    for (int i = 0; i < 4000; i++) ref_mem[i] = mem[i];
    do_byte(8'h51, 8'h3C, "t7_after", acc, wst);
    check_mem("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
